// File: rtl/uart_tx_cfg.sv
// Parameterised UART transmitter: start bit, DATA_BITS data bits (LSB first),
// optional odd/even parity, 1 or 2 stop bits. Valid/ready load, back-to-back capable.
module uart_tx_cfg #(
  parameter int CLK_FREQ  = 10000000,
  parameter int BAUDRATE  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_tx_cfg: CLK_FREQ / BAUDRATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_reg, state_next;
  logic [BAUD_W-1:0]    baud_reg, baud_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 done_reg, done_next;
  logic                 bit_end, last_stop, handshake;

  assign bit_end   = (baud_reg == BAUD_LAST);
  assign last_stop = (state_reg == STOP) && (bit_reg == STOP_LAST) && bit_end;
  assign tx_ready  = (state_reg == IDLE) || last_stop;
  assign handshake = tx_valid && tx_ready;

  assign tx      = tx_reg;
  assign busy    = (state_reg != IDLE);
  assign tx_done = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
      done_reg   <= done_next;
    end
  end

  // tx_next is the line level for the bit that state_next represents,
  // so tx is registered yet aligned with the state register.
  always_comb begin
    state_next  = state_reg;
    baud_next   = bit_end ? '0 : baud_reg + 1'b1;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    tx_next     = tx_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        tx_next   = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          bit_next   = '0;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (PARITY != 0) begin
              state_next = PAR;
              tx_next    = parity_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_next = STOP;
          bit_next   = '0;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_reg == STOP_LAST) begin
            done_next  = 1'b1;
            state_next = IDLE;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // Only possible in IDLE or the final stop cycle; overrides the above.
    if (handshake) begin
      state_next  = START;
      baud_next   = '0;
      bit_next    = '0;
      shift_next  = tx_data;
      parity_next = (PARITY == 1) ? ~^tx_data : ^tx_data;
      tx_next     = 1'b0;
    end
  end

endmodule
